cube_stream_loader: RTL and testbench

Upstream front-end for `network`. It accepts the 120-bit cube state as a framed byte stream over a valid/ready interface and assembles it into one word. It issues a single-cycle load to the network and holds the word stable while the network runs. It then captures the 4-bit classification on the network's valid rising edge and returns it over a second valid/ready interface, with framing-error and timeout detection.

---
 rtl/cube_stream_loader_pkg.sv | 25 ++
 rtl/cube_stream_loader_byte_assembler.sv | 60 ++++++
 rtl/cube_stream_loader.sv | 140 ++++++++++++++
 tb/tb_cube_stream_loader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cube_stream_loader_pkg.sv
// cube_stream_loader_pkg
//   Shared definitions for the cube stream loader. It holds the loader state
//   encodings, the default frame geometry and timeout, and a counter-width
//   helper.
package cube_stream_loader_pkg;

  localparam int LD_BYTES   = 15;
  localparam int LD_DATA_W  = 120;
  localparam int LD_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    LD_COLLECT = 3'd0,
    LD_DRAIN   = 3'd1,
    LD_LOAD    = 3'd2,
    LD_WAIT    = 3'd3,
    LD_OUT     = 3'd4
  } ld_state_e;

  // Width of a counter that must hold the values 0..n-1. The result is never
  // less than 1 bit.
  function automatic int ld_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cube_stream_loader_byte_assembler.sv
// cube_stream_loader_byte_assembler
//   Tracks the byte index within a frame and writes each accepted byte into
//   its lane of the assembled word. Byte 0 goes to the LSB lane. The index
//   returns to 0 after a byte flagged last and after the byte in the final lane.
// Ports
//   clk, rst_n  clock, async active-low reset
//   wr_en_i     accept the byte on data_i into the current lane
//   data_i      input byte
//   last_i      the byte on data_i closes the frame
//   net_d_o     assembled word (held between writes)
//   full_o      the current index is the final lane
//   last_o      a byte flagged last is being written this cycle
module cube_stream_loader_byte_assembler
  import cube_stream_loader_pkg::*;
#(
  parameter int BYTES  = LD_BYTES,
  parameter int DATA_W = LD_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [7:0]        data_i,
  input  logic              last_i,
  output logic [DATA_W-1:0] net_d_o,
  output logic              full_o,
  output logic              last_o
);

  localparam int IDX_W = ld_cnt_w(BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] net_d_q, net_d_d;

  assign full_o  = (idx_q == LAST_IDX);
  assign last_o  = wr_en_i & last_i;
  assign net_d_o = net_d_q;

  always_comb begin
    net_d_d = net_d_q;
    idx_d   = idx_q;
    if (wr_en_i) begin
      for (int k = 0; k < BYTES; k++) begin
        if (idx_q == IDX_W'(k)) net_d_d[8*k +: 8] = data_i;
      end
      idx_d = (last_i || full_o) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      net_d_q <= '0;
    end else begin
      idx_q   <= idx_d;
      net_d_q <= net_d_d;
    end
  end

endmodule

// File: rtl/cube_stream_loader.sv
// cube_stream_loader
//   Front-end for the cube classification network. It assembles a framed
//   byte stream into one word and pulses load to the network. It waits for
//   the rising edge of the network's valid and returns the 4-bit result over
//   a valid/ready port. Framing errors and timeouts give a one-cycle err pulse.
// Ports
//   clk, rst_n                  clock, async active-low reset
//   s_valid/s_ready/s_data/s_last  byte stream input
//   net_load, net_d             start pulse and word to the network
//   net_valid, net_q            network completion flag and result
//   m_valid/m_ready/m_data      result output
//   busy                        network loaded and not yet resolved
//   err                         one-cycle framing-error or timeout pulse
//
// state      | meaning
// -----------+-------------------------------------------------------
// LD_COLLECT | accepting frame bytes into net_d
// LD_DRAIN   | frame overran; discarding bytes up to the next s_last
// LD_LOAD    | one-cycle net_load, timeout counter cleared
// LD_WAIT    | waiting for net_valid rising edge or timeout
// LD_OUT     | m_valid high, m_data held until m_ready
module cube_stream_loader
  import cube_stream_loader_pkg::*;
#(
  parameter int BYTES   = LD_BYTES,
  parameter int DATA_W  = LD_DATA_W,
  parameter int TIMEOUT = LD_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              net_load,
  output logic [DATA_W-1:0] net_d,
  input  logic              net_valid,
  input  logic [3:0]        net_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [3:0]        m_data,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = ld_cnt_w(TIMEOUT);
  // The counter holds j-1 during the j-th WAIT cycle, so the limit is
  // reached when it reads TIMEOUT-1.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       m_data_q, m_data_d;
  logic             err_q, err_d;
  logic             net_valid_d_q;

  logic wr_en, asm_full, asm_last, nv_rise, timeout_hit;

  assign wr_en       = s_valid & (state_q == LD_COLLECT);
  assign nv_rise     = net_valid & ~net_valid_d_q;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  cube_stream_loader_byte_assembler #(
    .BYTES  (BYTES),
    .DATA_W (DATA_W)
  ) u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en_i (wr_en),
    .data_i  (s_data),
    .last_i  (s_last),
    .net_d_o (net_d),
    .full_o  (asm_full),
    .last_o  (asm_last)
  );

  assign s_ready  = (state_q == LD_COLLECT) || (state_q == LD_DRAIN);
  assign net_load = (state_q == LD_LOAD);
  assign busy     = (state_q == LD_LOAD) || (state_q == LD_WAIT);
  assign m_valid  = (state_q == LD_OUT);
  assign m_data   = m_data_q;
  assign err      = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_data_d = m_data_q;
    err_d    = 1'b0;
    case (state_q)
      LD_COLLECT: begin
        if (asm_last) begin
          if (asm_full) state_d = LD_LOAD;
          else          err_d   = 1'b1;
        end else if (wr_en && asm_full) begin
          err_d   = 1'b1;
          state_d = LD_DRAIN;
        end
      end
      LD_DRAIN: begin
        if (s_valid && s_last) state_d = LD_COLLECT;
      end
      LD_LOAD: begin
        cnt_d   = '0;
        state_d = LD_WAIT;
      end
      LD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A valid edge on the final allowed cycle still counts as a result.
        if (nv_rise) begin
          m_data_d = net_q;
          state_d  = LD_OUT;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = LD_COLLECT;
        end
      end
      LD_OUT: begin
        if (m_ready) state_d = LD_COLLECT;
      end
      default: state_d = LD_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LD_COLLECT;
      cnt_q         <= '0;
      m_data_q      <= '0;
      err_q         <= 1'b0;
      net_valid_d_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      m_data_q      <= m_data_d;
      err_q         <= err_d;
      net_valid_d_q <= net_valid;
    end
  end

endmodule

// File: tb/tb_cube_stream_loader.sv
// tb_cube_stream_loader
//   Directed bench for cube_stream_loader with a behavioural reference model.
//   The model keeps the frame as a byte queue and the wait as a cycle count.
//   Its outputs are checked every falling edge, and literal expectations pin
//   the key values and latencies.
module tb_cube_stream_loader;

  localparam int BYTES      = 15;
  localparam int DATA_W     = 120;
  localparam int TB_TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = '0;
  logic              s_last = 1'b0;
  logic              net_valid = 1'b0;
  logic [3:0]        net_q = '0;
  logic              m_ready = 1'b0;
  logic              s_ready, net_load, m_valid, busy, err;
  logic [DATA_W-1:0] net_d;
  logic [3:0]        m_data;

  always #5 clk = ~clk;

  cube_stream_loader #(
    .BYTES   (BYTES),
    .DATA_W  (DATA_W),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .net_load  (net_load),
    .net_d     (net_d),
    .net_valid (net_valid),
    .net_q     (net_q),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .busy      (busy),
    .err       (err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int P_COLLECT = 0;
  localparam int P_DRAIN   = 1;
  localparam int P_LOAD    = 2;
  localparam int P_WAIT    = 3;
  localparam int P_OUT     = 4;

  int                ph;
  logic [7:0]        frame[$];
  logic [DATA_W-1:0] md_word;
  logic [3:0]        md_res;
  int                wcnt;
  logic              md_prev_nv;
  logic              md_err;
  logic              md_err_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = P_COLLECT;
      frame.delete();
      md_word = '0;
      md_res = '0;
      wcnt = 0;
      md_prev_nv = 1'b0;
      md_err = 1'b0;
    end else begin
      md_err_n = 1'b0;
      case (ph)
        P_COLLECT: if (s_valid) begin
          md_word[8*frame.size() +: 8] = s_data;
          frame.push_back(s_data);
          if (s_last) begin
            if (frame.size() == BYTES) ph = P_LOAD;
            else md_err_n = 1'b1;
            frame.delete();
          end else if (frame.size() == BYTES) begin
            md_err_n = 1'b1;
            frame.delete();
            ph = P_DRAIN;
          end
        end
        P_DRAIN: if (s_valid && s_last) ph = P_COLLECT;
        P_LOAD: begin
          ph = P_WAIT;
          wcnt = 0;
        end
        P_WAIT: begin
          wcnt++;
          if (net_valid && !md_prev_nv) begin
            md_res = net_q;
            ph = P_OUT;
          end else if (wcnt == TB_TIMEOUT) begin
            md_err_n = 1'b1;
            ph = P_COLLECT;
          end
        end
        P_OUT: if (m_ready) ph = P_COLLECT;
        default: ph = P_COLLECT;
      endcase
      md_prev_nv = net_valid;
      md_err = md_err_n;
    end
  end

  always @(negedge clk) begin
    chk("model_s_ready",  s_ready,  (ph == P_COLLECT) || (ph == P_DRAIN));
    chk("model_net_load", net_load, ph == P_LOAD);
    chk("model_busy",     busy,     (ph == P_LOAD) || (ph == P_WAIT));
    chk("model_m_valid",  m_valid,  ph == P_OUT);
    chk("model_m_data",   m_data,   md_res);
    chk("model_err",      err,      md_err);
    chk("model_net_d",    net_d,    md_word);
  end

  int n_load = 0;
  int n_err  = 0;
  always @(negedge clk) begin
    if (net_load) n_load++;
    if (err) n_err++;
  end

  // ---------------- stimulus ----------------
  // All tasks start and end 2 time units after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    s_valid = 1'b1;
    s_data  = b;
    s_last  = l;
    tick(1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < BYTES; i++) send_byte(base + 8'(i), i == BYTES - 1);
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    tick(1);
    m_ready   = 1'b0;
    net_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"},  s_ready,  1);
    chk({tag, "_net_load"}, net_load, 0);
    chk({tag, "_m_valid"},  m_valid,  0);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_err"},      err,      0);
    chk({tag, "_net_d"},    net_d,    0);
    chk({tag, "_m_data"},   m_data,   0);
  endtask

  int e0, l0;

  initial begin
    #12;
    chk_reset_outputs("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick(1);

    // Clean frame 01..0F, network answers 7 after 50 cycles.
    l0 = n_load;
    send_frame(8'h01);
    chk("s1_net_load_latency", net_load, 1);
    chk("s1_busy_in_load", busy, 1);
    tick(1);
    chk("s1_net_load_one_cycle", net_load, 0);
    tick(49);
    net_valid = 1'b1;
    net_q     = 4'd7;
    tick(1);
    chk("s1_m_valid", m_valid, 1);
    chk("s1_m_data", m_data, 7);
    chk("s1_net_d", net_d, 120'h0F0E0D0C0B0A090807060504030201);
    tick(5);
    chk("s1_m_valid_held", m_valid, 1);
    chk("s1_m_data_held", m_data, 7);
    chk("s1_load_count", n_load - l0, 1);
    handshake();
    chk("s1_m_valid_dropped", m_valid, 0);

    // Short frame straight after the handshake, then a clean frame.
    e0 = n_err;
    l0 = n_load;
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), i == 4);
    chk("s2_err_pulse", err, 1);
    tick(1);
    chk("s2_err_one_cycle", err, 0);
    chk("s2_no_load", n_load - l0, 0);
    send_frame(8'h10);
    chk("s2_net_load", net_load, 1);
    tick(3);
    net_valid = 1'b1;
    net_q     = 4'hA;
    tick(1);
    chk("s2_m_valid", m_valid, 1);
    chk("s2_m_data", m_data, 4'hA);
    chk("s2_net_d", net_d, 120'h1E1D1C1B1A19181716151413121110);
    handshake();

    // Overrun: 15 bytes without s_last, then 3 drained bytes.
    e0 = n_err;
    l0 = n_load;
    for (int i = 0; i < BYTES; i++) send_byte(8'h30 + 8'(i), 1'b0);
    chk("s3_overrun_err", err, 1);
    chk("s3_drain_ready", s_ready, 1);
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), i == 2);
    tick(2);
    chk("s3_err_count", n_err - e0, 1);
    chk("s3_no_load", n_load - l0, 0);
    chk("s3_collect_ready", s_ready, 1);

    // Timeout with no network response.
    e0 = n_err;
    send_frame(8'h40);
    chk("s4_net_load", net_load, 1);
    tick(TB_TIMEOUT);
    chk("s4_no_err_before_limit", err, 0);
    tick(1);
    chk("s4_timeout_err", err, 1);
    chk("s4_not_busy", busy, 0);
    chk("s4_ready", s_ready, 1);
    tick(1);
    chk("s4_err_one_cycle", err, 0);
    chk("s4_no_m_valid", m_valid, 0);
    chk("s4_err_count", n_err - e0, 1);

    // Valid edge lands on the last allowed WAIT cycle: edge wins.
    e0 = n_err;
    send_frame(8'h50);
    chk("s4b_net_load", net_load, 1);
    tick(TB_TIMEOUT);
    net_valid = 1'b1;
    net_q     = 4'd3;
    tick(1);
    chk("s4b_m_valid", m_valid, 1);
    chk("s4b_no_err", err, 0);
    chk("s4b_m_data", m_data, 3);
    handshake();
    chk("s4b_err_count", n_err - e0, 0);

    // net_valid high before load is not an edge.
    net_valid = 1'b1;
    net_q     = 4'd5;
    send_frame(8'h60);
    tick(11);
    chk("s5_no_capture", m_valid, 0);
    chk("s5_busy", busy, 1);
    net_valid = 1'b0;
    tick(1);
    net_valid = 1'b1;
    tick(1);
    chk("s5_m_valid", m_valid, 1);
    chk("s5_m_data", m_data, 5);
    handshake();

    // Reset during byte 9.
    for (int i = 0; i < 8; i++) send_byte(8'h70 + 8'(i), 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h78;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("s6_rst_frame");
    s_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Reset during WAIT.
    l0 = n_load;
    send_frame(8'h80);
    tick(5);
    chk("s6_busy_before_rst", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("s6_rst_wait");
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("s6_load_count", n_load - l0, 1);
    chk("s6_no_m_valid", m_valid, 0);

    // A full frame after reset behaves as the first one.
    send_frame(8'h01);
    chk("s7_net_load", net_load, 1);
    tick(50);
    net_valid = 1'b1;
    net_q     = 4'd7;
    tick(1);
    chk("s7_m_valid", m_valid, 1);
    chk("s7_m_data", m_data, 7);
    chk("s7_net_d", net_d, 120'h0F0E0D0C0B0A090807060504030201);
    handshake();
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
